// File: rtl/my_sync_sched.sv
// Sync square-wave sequencer: start/stop, continuous or N-pulse bursts,
// with host half-period updates deferred to toggle boundaries.
module my_sync_sched #(
    parameter int CNT_W          = 32,
    parameter int BURST_W        = 16,
    parameter int DEFAULT_PERIOD = 500000
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_cfg_valid,
    input  logic [CNT_W-1:0]   i_cfg_period,
    output logic               o_cfg_ready,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic [BURST_W-1:0] i_burst_len,
    output logic               o_sync_out,
    output logic               o_sync_rise,
    output logic               o_sync_fall,
    output logic               o_busy,
    output logic               o_done,
    output logic [BURST_W-1:0] o_pulse_cnt,
    output logic [CNT_W-1:0]   o_period_active
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STOPPING
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [CNT_W-1:0]   pend_q, pend_d;
    logic               pend_vld_q, pend_vld_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [BURST_W-1:0] pulse_q, pulse_d;
    logic               sync_q, sync_d;
    logic               rise_q, rise_d;
    logic               fall_q, fall_d;
    logic               done_q, done_d;

    logic               cfg_accept;
    logic [CNT_W-1:0]   cfg_clamped;
    logic               toggle;
    logic [BURST_W-1:0] pulse_inc;
    logic               burst_hit;
    logic               go_idle;
    logic               apply_pend;

    assign cfg_accept  = i_cfg_valid && !pend_vld_q;
    assign cfg_clamped = (i_cfg_period == '0) ? CNT_W'(1) : i_cfg_period;
    assign toggle      = (cnt_q == period_q - CNT_W'(1));
    assign pulse_inc   = pulse_q + BURST_W'(1);
    assign burst_hit   = (burst_q != '0) && (pulse_inc == burst_q);

    always_comb begin
        state_d    = state_q;
        period_d   = period_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        cnt_d      = cnt_q;
        burst_d    = burst_q;
        pulse_d    = pulse_q;
        sync_d     = sync_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        done_d     = 1'b0;
        go_idle    = 1'b0;
        apply_pend = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start && !i_stop) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    burst_d = i_burst_len;
                    pulse_d = '0;
                end
            end
            ST_RUN, ST_STOPPING: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A stop while low ends at once; a stop while high waits for the fall.
                if (state_q == ST_RUN && i_stop && !sync_q) begin
                    go_idle = 1'b1;
                end else if (toggle) begin
                    cnt_d      = '0;
                    sync_d     = !sync_q;
                    apply_pend = 1'b1;
                    if (!sync_q) begin
                        rise_d = 1'b1;
                    end else begin
                        fall_d  = 1'b1;
                        pulse_d = pulse_inc;
                        if (burst_hit || state_q == ST_STOPPING || i_stop) begin
                            go_idle = 1'b1;
                        end
                    end
                end else if (state_q == ST_RUN && i_stop) begin
                    state_d = ST_STOPPING;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (go_idle) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            done_d     = 1'b1;
            apply_pend = 1'b1;
        end

        if (apply_pend && pend_vld_q) begin
            period_d   = pend_q;
            pend_vld_d = 1'b0;
        end

        // Once idle there is no later toggle, so a value arriving now goes straight to P.
        if (cfg_accept) begin
            if (state_q == ST_IDLE || go_idle) begin
                period_d = cfg_clamped;
            end else begin
                pend_d     = cfg_clamped;
                pend_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            period_q   <= CNT_W'(DEFAULT_PERIOD);
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            cnt_q      <= '0;
            burst_q    <= '0;
            pulse_q    <= '0;
            sync_q     <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            period_q   <= period_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            cnt_q      <= cnt_d;
            burst_q    <= burst_d;
            pulse_q    <= pulse_d;
            sync_q     <= sync_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            done_q     <= done_d;
        end
    end

    assign o_cfg_ready     = !pend_vld_q;
    assign o_sync_out      = sync_q;
    assign o_sync_rise     = rise_q;
    assign o_sync_fall     = fall_q;
    assign o_busy          = (state_q != ST_IDLE);
    assign o_done          = done_q;
    assign o_pulse_cnt     = pulse_q;
    assign o_period_active = period_q;

endmodule
